// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - in-order fetch queue with redirect flush; optional counters under FETCH_QUEUE_PERF_EN
module fetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned ILEN     = 32
) (
    input  logic            clk_i,
    input  logic            rstn_i,
    input  logic            taken_branch_i,
    input  logic [31:0]     new_pc_i,
    input  logic            stall_i,
    output logic            req_valid_o,
    input  logic            req_ready_i,
    output logic [31:0]     req_pc_o,
    input  logic            rsp_valid_i,
    input  logic [ILEN-1:0] rsp_instr_i,
    output logic [31:0]     pc_o,
    output logic [ILEN-1:0] instr_o,
    output logic            valid_o,
    output logic [31:0]     kanata_id_o
`ifdef FETCH_QUEUE_PERF_EN
    ,
    output logic [31:0]     perf_empty_cycles_o,
    output logic [31:0]     perf_dropped_rsp_o
`endif
);
    localparam int unsigned CW  = $clog2(DEPTH + 1);
    localparam int unsigned CW1 = CW + 1;
    localparam int unsigned PW  = $clog2(DEPTH);
    localparam logic [CW:0] DEPTH_W = CW1'(DEPTH);

    logic [31:0]     fetch_pc_q, fetch_pc_d;
    logic [CW-1:0]   occ_q, occ_d;
    logic [CW-1:0]   inflight_q, inflight_d;
    logic [CW-1:0]   drop_q, drop_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]   pend_wr_q, pend_wr_d, pend_rd_q, pend_rd_d;
    logic [31:0]     kanata_q, kanata_d;
    logic [31:0]     last_pc_q;
    logic [ILEN-1:0] last_instr_q;

    // Data FIFO (delivered to decode) and the PC side queue of outstanding requests
    logic [31:0]     fifo_pc    [DEPTH];
    logic [ILEN-1:0] fifo_instr [DEPTH];
    logic [31:0]     pend_pc    [DEPTH];

    logic            issue, rsp_drop, push, pop;
    logic [CW:0]     load;

    assign load        = {1'b0, occ_q} + {1'b0, inflight_q};
    assign req_valid_o = rstn_i & ~taken_branch_i & (load < DEPTH_W);
    assign req_pc_o    = fetch_pc_q;
    assign valid_o     = (occ_q != '0);
    assign issue       = req_valid_o & req_ready_i;
    assign rsp_drop    = rsp_valid_i & (taken_branch_i | (drop_q != '0));
    assign push        = rsp_valid_i & ~rsp_drop;
    assign pop         = valid_o & ~stall_i & ~taken_branch_i;
    assign pc_o        = valid_o ? fifo_pc[rd_ptr_q] : last_pc_q;
    assign instr_o     = valid_o ? fifo_instr[rd_ptr_q] : last_instr_q;
    assign kanata_id_o = kanata_q;

    // Next-state: normal issue/response/pop, then redirect overrides everything
    always_comb begin
        fetch_pc_d = issue ? fetch_pc_q + 32'd4 : fetch_pc_q;
        inflight_d = inflight_q + CW'(issue) - CW'(rsp_valid_i);
        pend_wr_d  = issue ? pend_wr_q + PW'(1) : pend_wr_q;
        pend_rd_d  = rsp_valid_i ? pend_rd_q + PW'(1) : pend_rd_q;
        drop_d     = (rsp_valid_i && (drop_q != '0)) ? drop_q - CW'(1) : drop_q;
        wr_ptr_d   = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d   = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
        occ_d      = occ_q + CW'(push) - CW'(pop);
        kanata_d   = pop ? kanata_q + 32'd1 : kanata_q;
        if (taken_branch_i) begin
            fetch_pc_d = new_pc_i;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            occ_d      = '0;
            drop_d     = inflight_q - CW'(rsp_valid_i);
        end
    end

    // Control state registers
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            fetch_pc_q   <= RESET_PC;
            occ_q        <= '0;
            inflight_q   <= '0;
            drop_q       <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            pend_wr_q    <= '0;
            pend_rd_q    <= '0;
            kanata_q     <= '0;
            last_pc_q    <= '0;
            last_instr_q <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            occ_q      <= occ_d;
            inflight_q <= inflight_d;
            drop_q     <= drop_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            pend_wr_q  <= pend_wr_d;
            pend_rd_q  <= pend_rd_d;
            kanata_q   <= kanata_d;
            if (valid_o) begin
                last_pc_q    <= pc_o;
                last_instr_q <= instr_o;
            end
        end
    end

    // Storage arrays: PC captured at issue, paired with its response on write
    always_ff @(posedge clk_i) begin
        if (issue) begin
            pend_pc[pend_wr_q] <= fetch_pc_q;
        end
        if (push) begin
            fifo_pc[wr_ptr_q]    <= pend_pc[pend_rd_q];
            fifo_instr[wr_ptr_q] <= rsp_instr_i;
        end
    end

    // Buffered plus outstanding work can never exceed the FIFO capacity
    assert property (@(posedge clk_i) disable iff (!rstn_i) load <= DEPTH_W);

`ifdef FETCH_QUEUE_PERF_EN
    logic [31:0] perf_empty_q, perf_drop_q;

    // Saturating counters for empty-output cycles and discarded responses
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            perf_empty_q <= '0;
            perf_drop_q  <= '0;
        end else begin
            if (!valid_o && (perf_empty_q != 32'hFFFF_FFFF)) begin
                perf_empty_q <= perf_empty_q + 32'd1;
            end
            if (rsp_drop && (perf_drop_q != 32'hFFFF_FFFF)) begin
                perf_drop_q <= perf_drop_q + 32'd1;
            end
        end
    end

    assign perf_empty_cycles_o = perf_empty_q;
    assign perf_dropped_rsp_o  = perf_drop_q;
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// tb/tb_fetch_queue.sv - scoreboard bench for fetch_queue with a modelled in-order icache
module tb_fetch_queue;
    localparam int DEPTH = 4;

    logic        clk_i = 1'b0;
    logic        rstn_i;
    logic        taken_branch_i;
    logic [31:0] new_pc_i;
    logic        stall_i;
    logic        req_valid_o;
    logic        req_ready_i;
    logic [31:0] req_pc_o;
    logic        rsp_valid_i;
    logic [31:0] rsp_instr_i;
    logic [31:0] pc_o;
    logic [31:0] instr_o;
    logic        valid_o;
    logic [31:0] kanata_id_o;
`ifdef FETCH_QUEUE_PERF_EN
    logic [31:0] perf_empty_cycles_o;
    logic [31:0] perf_dropped_rsp_o;
`endif

    fetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'h0), .ILEN(32)) dut (
        .clk_i          (clk_i),
        .rstn_i         (rstn_i),
        .taken_branch_i (taken_branch_i),
        .new_pc_i       (new_pc_i),
        .stall_i        (stall_i),
        .req_valid_o    (req_valid_o),
        .req_ready_i    (req_ready_i),
        .req_pc_o       (req_pc_o),
        .rsp_valid_i    (rsp_valid_i),
        .rsp_instr_i    (rsp_instr_i),
        .pc_o           (pc_o),
        .instr_o        (instr_o),
        .valid_o        (valid_o),
        .kanata_id_o    (kanata_id_o)
`ifdef FETCH_QUEUE_PERF_EN
        ,
        .perf_empty_cycles_o (perf_empty_cycles_o),
        .perf_dropped_rsp_o  (perf_dropped_rsp_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } sb_t;

    sb_t         sb[$];
    logic [31:0] icq[$];
    int          checks   = 0;
    int          failures = 0;
    int          drop_m   = 0;
    int          issued   = 0;
    logic [31:0] exp_pc   = 32'h0;
    logic [31:0] kid_m    = 32'h0;
    logic        ic_hold  = 1'b0;
    logic        cap_en   = 1'b0;
    logic [31:0] cap_pc   = 32'h0;

    function automatic logic [31:0] instr_of(input logic [31:0] pc);
        return (pc * 32'h9E37_79B1) ^ 32'h5A5A_5A5A;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rstn_i         = 1'b0;
        taken_branch_i = 1'b0;
        new_pc_i       = 32'h0;
        stall_i        = 1'b0;
        req_ready_i    = 1'b0;
        rsp_valid_i    = 1'b0;
        rsp_instr_i    = 32'h0;
        #1;
        chk("rst_valid", valid_o, 1'b0);
        chk("rst_req_valid", req_valid_o, 1'b0);
        chk("rst_pc", pc_o, 32'h0);
        chk("rst_instr", instr_o, 32'h0);
        chk("rst_kanata", kanata_id_o, 32'h0);
`ifdef FETCH_QUEUE_PERF_EN
        chk("rst_perf_empty", perf_empty_cycles_o, 32'h0);
        chk("rst_perf_drop", perf_dropped_rsp_o, 32'h0);
`endif
        @(posedge clk_i);
        @(negedge clk_i);
        rstn_i = 1'b1;
        sb.delete();
        icq.delete();
        drop_m  = 0;
        issued  = 0;
        exp_pc  = 32'h0;
        kid_m   = 32'h0;
        ic_hold = 1'b0;
    endtask

    // One clock cycle: drive icache response, check outputs, advance the model
    task automatic tick();
        logic        rsp_now;
        logic [31:0] rsp_pc;
        logic        exp_req_v;
        int          occ_m;
        int          infl_m;
        sb_t         e;
        rsp_now     = !ic_hold && (icq.size() != 0);
        rsp_pc      = rsp_now ? icq[0] : 32'h0;
        rsp_valid_i = rsp_now;
        rsp_instr_i = rsp_now ? instr_of(rsp_pc) : 32'h0;
        #1;
        occ_m     = sb.size();
        infl_m    = icq.size();
        exp_req_v = !taken_branch_i && (occ_m + infl_m < DEPTH);
        chk("req_valid", req_valid_o, exp_req_v);
        chk("valid", valid_o, occ_m != 0);
        if (valid_o && !stall_i && !taken_branch_i && (sb.size() != 0)) begin
            chk("pc", pc_o, sb[0].pc);
            chk("instr", instr_o, sb[0].instr);
            chk("kanata", kanata_id_o, kid_m);
            if (cap_en) begin
                cap_pc = pc_o;
                cap_en = 1'b0;
            end
            void'(sb.pop_front());
            kid_m = kid_m + 32'd1;
        end
        if (rsp_now) begin
            void'(icq.pop_front());
            if (taken_branch_i || drop_m > 0) begin
                if (drop_m > 0) drop_m--;
            end else begin
                e.pc    = rsp_pc;
                e.instr = instr_of(rsp_pc);
                sb.push_back(e);
            end
        end
        if (req_valid_o && req_ready_i) begin
            chk("req_pc", req_pc_o, exp_pc);
            icq.push_back(exp_pc);
            exp_pc = exp_pc + 32'd4;
            issued++;
        end
        if (taken_branch_i) begin
            sb.delete();
            drop_m = icq.size();
            exp_pc = new_pc_i;
        end
        @(posedge clk_i);
        @(negedge clk_i);
    endtask

    initial begin
        @(negedge clk_i);
        do_reset();

        // Streaming: 1-cycle icache, no stall
        req_ready_i = 1'b1;
        for (int i = 0; i < 12; i++) tick();

        // Stall fills the queue with exactly DEPTH entries, then drains in order
        do_reset();
        req_ready_i = 1'b1;
        stall_i     = 1'b1;
        for (int i = 0; i < 8; i++) tick();
        chk("stall_issued", issued, DEPTH);
        chk("stall_req_valid", req_valid_o, 1'b0);
        stall_i = 1'b0;
        for (int i = 0; i < 10; i++) tick();

        // Redirect with 3 requests in flight
        do_reset();
        req_ready_i = 1'b1;
        stall_i     = 1'b1;
        ic_hold     = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        chk("three_inflight", issued, 3);
        taken_branch_i = 1'b1;
        new_pc_i       = 32'h0000_0100;
        tick();
        taken_branch_i = 1'b0;
        ic_hold        = 1'b0;
        stall_i        = 1'b0;
        cap_en         = 1'b1;
        for (int i = 0; i < 12; i++) tick();
        chk("first_after_redirect", cap_pc, 32'h0000_0100);
`ifdef FETCH_QUEUE_PERF_EN
        chk("perf_dropped", perf_dropped_rsp_o, 32'd3);
`endif

        // Redirect coinciding with a response, 2 in flight
        do_reset();
        req_ready_i = 1'b1;
        ic_hold     = 1'b1;
        for (int i = 0; i < 2; i++) tick();
        req_ready_i    = 1'b0;
        ic_hold        = 1'b0;
        taken_branch_i = 1'b1;
        new_pc_i       = 32'h0000_0200;
        tick();
        chk("redirect_no_valid", valid_o, 1'b0);
        taken_branch_i = 1'b0;
        req_ready_i    = 1'b1;
        cap_en         = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        chk("first_after_rsp_redirect", cap_pc, 32'h0000_0200);

        // PC wrap through 0xFFFFFFFC with a stall pulse in mid-stream
        taken_branch_i = 1'b1;
        new_pc_i       = 32'hFFFF_FFF8;
        tick();
        taken_branch_i = 1'b0;
        cap_en         = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        stall_i = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        stall_i = 1'b0;
        for (int i = 0; i < 8; i++) tick();
        chk("wrap_first", cap_pc, 32'hFFFF_FFF8);

        // Asynchronous reset with a non-empty FIFO
        do_reset();
        req_ready_i = 1'b1;
        stall_i     = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        chk("pre_reset_valid", valid_o, 1'b1);
        chk("pre_reset_req_valid", req_valid_o, 1'b1);
        #2;
        do_reset();
        req_ready_i = 1'b1;
        for (int i = 0; i < 8; i++) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
